// File: rtl/const_fold_pkg.sv
// Shared definitions for the constant-fold block accumulator.
// State encoding, default parameters and the count-width helper.
package const_fold_pkg;

    localparam int          DEF_WIDTH    = 2**2 * 2**3;
    localparam int          DEF_DEPTH    = 2**2;
    localparam logic [47:0] DEF_TAG_MASK = 48'hFF00_0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // One extra bit so the count can hold DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/const_fold_acc_dp.sv
// Accumulator / tag / flag datapath for one block of samples.
// Clear wins over enable; the FSM never asserts both together.
module const_fold_acc_dp
    import const_fold_pkg::*;
#(
    parameter int          WIDTH    = DEF_WIDTH,
    parameter logic [47:0] TAG_MASK = DEF_TAG_MASK
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [WIDTH-1:0]   in1,
    input  logic [2*WIDTH-1:0] in2,
    input  logic [47:0]        in3,
    output logic [2*WIDTH-1:0] acc,
    output logic [47:0]        tag,
    output logic               flag
);

    logic [2*WIDTH-1:0] in1_ext;

    assign in1_ext = {{WIDTH{1'b0}}, in1};

    // Fold each accepted sample into sum (wrapping), tag and flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            tag  <= '0;
            flag <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            tag  <= '0;
            flag <= 1'b0;
        end else if (enable) begin
            acc  <= acc + in2 + in1_ext;
            tag  <= tag ^ (in3 & TAG_MASK);
            flag <= flag | in1[1];
        end
    end

endmodule

// File: rtl/const_fold_accum.sv
// Block accumulator: folds DEPTH samples, then holds the result
// in FLUSH until downstream takes it.
module const_fold_accum
    import const_fold_pkg::*;
#(
    parameter int          WIDTH    = DEF_WIDTH,
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [47:0] TAG_MASK = DEF_TAG_MASK
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [2*WIDTH-1:0] in2,
    input  logic [47:0]        in3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_sum,
    output logic [47:0]        out_tag,
    output logic               out_flag
);

    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("const_fold_accum: DEPTH must be a power of two in 2..16");
    end

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;
    logic               accept;
    logic               clear;
    logic               last;
    logic [2*WIDTH-1:0] acc;
    logic [47:0]        tag;
    logic               flag;

    // Ready is held low while reset is asserted.
    assign in_ready  = reset_n && (state != FLUSH);
    assign out_valid = (state == FLUSH);
    assign accept    = in_valid && in_ready;
    assign last      = (count == CW'(DEPTH - 1));

    // State and sample-count registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state, next-count and datapath clear.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACCUM;
                    count_nxt = CW'(1);
                end
            end
            ACCUM: begin
                if (accept) begin
                    count_nxt = count + CW'(1);
                    if (last) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    clear     = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
                clear     = 1'b1;
            end
        endcase
    end

    const_fold_acc_dp #(
        .WIDTH    (WIDTH),
        .TAG_MASK (TAG_MASK)
    ) u_dp (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .enable  (accept),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .acc     (acc),
        .tag     (tag),
        .flag    (flag)
    );

    // Results are only visible while a block is being offered.
    assign out_sum  = out_valid ? acc  : '0;
    assign out_tag  = out_valid ? tag  : '0;
    assign out_flag = out_valid ? flag : 1'b0;

endmodule

// File: doc/const_fold_accum.md
CONST_FOLD_ACCUM -- requirements
Module: const_fold_accum

Interface
REQ-001 Parameter WIDTH, default 2**2 * 2**3 (=32), sample word width.
REQ-002 Parameter DEPTH, default 2**2 (=4), samples per block (power of two, 2..16).
REQ-003 Parameter TAG_MASK, default 48'hFF00_0000_0000, mask applied to tag input.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_ready  output  1  block accepts sample this cycle.
REQ-008 in1  input  WIDTH  narrow operand, zero-extended.
REQ-009 in2  input  2*WIDTH  wide operand.
REQ-010 in3  input  48  tag word.
REQ-011 out_valid  output  1  block result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_sum  output  2*WIDTH  block sum.
REQ-014 out_tag  output  48  masked XOR of block tags.
REQ-015 out_flag  output  1  OR of in1[1] over block.

Function
REQ-016 Accept = in_valid && in_ready; no other event updates accumulator.
REQ-017 FSM states IDLE, ACCUM, FLUSH; in_ready = 1 in IDLE and ACCUM, 0 in FLUSH.
REQ-018 IDLE: on accept -> ACCUM, count = 1; else stay.
REQ-019 ACCUM: on accept count += 1; on DEPTH-th accept -> FLUSH next cycle.
REQ-020 DEPTH-th accept in IDLE (DEPTH=1 not allowed) never occurs; DEPTH>=2 enforced by parameter check.
REQ-021 Per accept: acc = acc + in2 + {WIDTH'b0, in1}, modulo 2**(2*WIDTH); carry-out discarded, no saturation.
REQ-022 Per accept: tag = tag ^ (in3 & TAG_MASK); flag = flag | in1[1].
REQ-023 out_valid = 1 exactly in FLUSH; asserted the cycle after the DEPTH-th accept (latency 1).
REQ-024 out_sum, out_tag, out_flag driven from registers; stable while out_valid && !out_ready.
REQ-025 FLUSH with out_ready = 1 -> IDLE next cycle; acc, tag, flag, count cleared same edge.
REQ-026 No sample accepted in the FLUSH-exit cycle (in_ready already 0); first new accept earliest next cycle.
REQ-027 out_sum/out_tag/out_flag read 0 when out_valid = 0.
REQ-028 in1/in2/in3 ignored (don't-care) when no accept.

Reset
REQ-029 reset_n low asynchronously forces state IDLE, count 0, acc 0, tag 0, flag 0.
REQ-030 During reset: in_ready 0, out_valid 0, out_sum 0, out_tag 0, out_flag 0.
REQ-031 Reset mid-block or mid-FLUSH discards partial/pending result; no output after release.
REQ-032 First accept possible on first rising edge with reset_n high.

Structure
REQ-033 Shared package const_fold_pkg holds state encoding (IDLE=2'd0, ACCUM=2'd1, FLUSH=2'd2), default WIDTH/DEPTH/TAG_MASK constants, as constant expressions.
REQ-034 Count register width $clog2(DEPTH)+1, derived via constant expression.
REQ-035 One sub-module const_fold_acc_dp: accumulator/tag/flag datapath with clear and enable; FSM stays in top.

Verification
REQ-036 Reset then 4 accepts in1=32'hFFFF_FF26, in2=0, in3=0 -> out_valid next cycle, out_sum=64'h3_FFFF_FC98, out_flag=1, out_tag=0.
REQ-037 4 accepts in1=1, in2=64'hFFFF_FFFF_FFFF_FFFF -> out_sum=0 (wrap), out_flag=0.
REQ-038 Tags in3=48'hFFFF_FFFF_FFFF on sample 1 only -> out_tag=48'hFF00_0000_0000; on samples 1 and 2 -> out_tag=0.
REQ-039 out_ready held 0 for 5 cycles in FLUSH -> outputs unchanged, in_ready=0; out_ready=1 -> IDLE, outputs 0 next cycle.
REQ-040 2 accepts (in1=5), reset_n pulse low, then 4 accepts in1=3, in2=0 -> out_sum=12, no earlier out_valid.
REQ-041 in_valid toggling every other cycle -> only accepted samples counted; out_valid after 4th accept.
